// File: rtl/sap_control_core.sv
// SAP-1 execution core: instruction register, 8-bit add/sub ALU with latched
// zero/overflow flags, and a six-step T-state sequencer that emits the bus
// load/enable strobes for PC, MAR, RAM and registers A/B/OUT.
module sap_control_core (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_bus,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_bus,
    output logic       o_bus_en,
    output logic [3:0] o_opcode,
    output logic       o_flag_zero,
    output logic       o_flag_overflow,
    output logic [2:0] o_state,
    output logic       o_halt,
    output logic       o_memory_address_in,
    output logic       o_ram_in,
    output logic       o_ram_out,
    output logic       o_register_a_in,
    output logic       o_register_a_out,
    output logic       o_register_b_in,
    output logic       o_register_output_in,
    output logic       o_program_counter_increment,
    output logic       o_program_counter_out,
    output logic       o_program_counter_jump
);

    typedef enum logic [2:0] {
        StT1 = 3'd0,
        StT2 = 3'd1,
        StT3 = 3'd2,
        StT4 = 3'd3,
        StT5 = 3'd4,
        StT6 = 3'd5
    } state_t;

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpSta = 4'b0011;
    localparam logic [3:0] OpJmp = 4'b0100;
    localparam logic [3:0] OpJz  = 4'b0101;
    localparam logic [3:0] OpJc  = 4'b0110;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    state_t     r_state;
    state_t     w_state_d;
    logic [7:0] r_ir;
    logic       r_flag_zero;
    logic       r_flag_overflow;
    logic       r_halted;

    logic [3:0] w_opcode;
    logic       w_ir_in;
    logic       w_ir_out;
    logic       w_alu_out;
    logic       w_subtract;
    logic       w_halt;
    logic       w_mar_in;
    logic       w_ram_in;
    logic       w_ram_out;
    logic       w_a_in;
    logic       w_a_out;
    logic       w_b_in;
    logic       w_out_in;
    logic       w_pc_inc;
    logic       w_pc_out;
    logic       w_pc_jump;

    logic [7:0] w_b_operand;
    logic [8:0] w_sum;
    logic [7:0] w_result;

    assign w_opcode = r_ir[7:4];

    // Subtraction is a + ~b + 1, so carry out of bit 7 means "no borrow".
    assign w_b_operand = w_subtract ? ~i_b : i_b;
    assign w_sum       = {1'b0, i_a} + {1'b0, w_b_operand} + {8'd0, w_subtract};
    assign w_result    = w_sum[7:0];

    // Control strobes decoded from T-state, opcode and flags; forced low during reset.
    always_comb begin
        w_ir_in    = 1'b0;
        w_ir_out   = 1'b0;
        w_alu_out  = 1'b0;
        w_subtract = 1'b0;
        w_halt     = 1'b0;
        w_mar_in   = 1'b0;
        w_ram_in   = 1'b0;
        w_ram_out  = 1'b0;
        w_a_in     = 1'b0;
        w_a_out    = 1'b0;
        w_b_in     = 1'b0;
        w_out_in   = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_out   = 1'b0;
        w_pc_jump  = 1'b0;
        if (i_reset) begin
            case (r_state)
                StT1: begin
                    w_pc_out = 1'b1;
                    w_mar_in = 1'b1;
                end
                StT2: w_pc_inc = 1'b1;
                StT3: begin
                    w_ram_out = 1'b1;
                    w_ir_in   = 1'b1;
                end
                StT4: begin
                    case (w_opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            w_ir_out = 1'b1;
                            w_mar_in = 1'b1;
                        end
                        OpJmp: begin
                            w_ir_out  = 1'b1;
                            w_pc_jump = 1'b1;
                        end
                        OpJz: begin
                            w_ir_out  = r_flag_zero;
                            w_pc_jump = r_flag_zero;
                        end
                        OpJc: begin
                            w_ir_out  = r_flag_overflow;
                            w_pc_jump = r_flag_overflow;
                        end
                        OpOut: begin
                            w_a_out  = 1'b1;
                            w_out_in = 1'b1;
                        end
                        OpHlt:   w_halt = 1'b1;
                        default: ;
                    endcase
                end
                StT5: begin
                    case (w_opcode)
                        OpLda: begin
                            w_ram_out = 1'b1;
                            w_a_in    = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            w_ram_out = 1'b1;
                            w_b_in    = 1'b1;
                        end
                        OpSta: begin
                            w_a_out  = 1'b1;
                            w_ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT6: begin
                    if (w_opcode == OpAdd || w_opcode == OpSub) begin
                        w_alu_out  = 1'b1;
                        w_a_in     = 1'b1;
                        w_subtract = (w_opcode == OpSub);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next T-state: short instructions return to T1 early, HLT parks in T4.
    always_comb begin
        w_state_d = StT1;
        case (r_state)
            StT1: w_state_d = StT2;
            StT2: w_state_d = StT3;
            StT3: w_state_d = StT4;
            StT4: begin
                case (w_opcode)
                    OpLda, OpAdd, OpSub, OpSta: w_state_d = StT5;
                    OpHlt:                      w_state_d = StT4;
                    default:                    w_state_d = StT1;
                endcase
            end
            StT5: w_state_d = (w_opcode == OpSta) ? StT1 : StT6;
            StT6: w_state_d = StT1;
            default: w_state_d = StT1;
        endcase
        if (r_halted) begin
            w_state_d = StT4;
        end
    end

    // Sequencer, instruction register, halt latch and ALU flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= StT1;
            r_ir            <= 8'h00;
            r_flag_zero     <= 1'b0;
            r_flag_overflow <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_ir_in) begin
                r_ir <= i_bus;
            end
            if (w_halt) begin
                r_halted <= 1'b1;
            end
            if (w_alu_out) begin
                r_flag_zero     <= (w_result == 8'h00);
                r_flag_overflow <= w_sum[8];
            end
        end
    end

    // Bus source select: IR operand or ALU result, never both.
    always_comb begin
        o_bus = 8'h00;
        if (w_ir_out) begin
            o_bus = {4'b0000, r_ir[3:0]};
        end else if (w_alu_out) begin
            o_bus = w_result;
        end
    end

    assign o_bus_en                    = w_ir_out | w_alu_out;
    assign o_opcode                    = w_opcode;
    assign o_flag_zero                 = r_flag_zero;
    assign o_flag_overflow             = r_flag_overflow;
    assign o_state                     = r_state;
    assign o_halt                      = w_halt | (r_halted & i_reset);
    assign o_memory_address_in         = w_mar_in;
    assign o_ram_in                    = w_ram_in;
    assign o_ram_out                   = w_ram_out;
    assign o_register_a_in             = w_a_in;
    assign o_register_a_out            = w_a_out;
    assign o_register_b_in             = w_b_in;
    assign o_register_output_in        = w_out_in;
    assign o_program_counter_increment = w_pc_inc;
    assign o_program_counter_out       = w_pc_out;
    assign o_program_counter_jump      = w_pc_jump;

endmodule

// File: tb/tb_sap_control_core.sv
// Self-checking bench for sap_control_core: a per-cycle vector table covering a
// small program, plus hand-written reset and halt sequences.
module tb_sap_control_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_bus;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic [7:0] o_bus;
    logic       o_bus_en;
    logic [3:0] o_opcode;
    logic       o_flag_zero;
    logic       o_flag_overflow;
    logic [2:0] o_state;
    logic       o_halt, o_mi, o_ri, o_ro, o_ai, o_ao, o_bi, o_oi, o_pi, o_po, o_j;
    logic [10:0] act_ctl;

    localparam logic [10:0] H  = 11'h400;
    localparam logic [10:0] MI = 11'h200;
    localparam logic [10:0] RI = 11'h100;
    localparam logic [10:0] RO = 11'h080;
    localparam logic [10:0] AI = 11'h040;
    localparam logic [10:0] AO = 11'h020;
    localparam logic [10:0] BI = 11'h010;
    localparam logic [10:0] OI = 11'h008;
    localparam logic [10:0] PI = 11'h004;
    localparam logic [10:0] PO = 11'h002;
    localparam logic [10:0] J  = 11'h001;
    localparam logic [10:0] NONE = 11'h000;

    sap_control_core dut (
        .i_clock                     (clk),
        .i_reset                     (rst_n),
        .i_bus                       (i_bus),
        .i_a                         (i_a),
        .i_b                         (i_b),
        .o_bus                       (o_bus),
        .o_bus_en                    (o_bus_en),
        .o_opcode                    (o_opcode),
        .o_flag_zero                 (o_flag_zero),
        .o_flag_overflow             (o_flag_overflow),
        .o_state                     (o_state),
        .o_halt                      (o_halt),
        .o_memory_address_in         (o_mi),
        .o_ram_in                    (o_ri),
        .o_ram_out                   (o_ro),
        .o_register_a_in             (o_ai),
        .o_register_a_out            (o_ao),
        .o_register_b_in             (o_bi),
        .o_register_output_in        (o_oi),
        .o_program_counter_increment (o_pi),
        .o_program_counter_out       (o_po),
        .o_program_counter_jump      (o_j)
    );

    assign act_ctl = {o_halt, o_mi, o_ri, o_ro, o_ai, o_ao, o_bi, o_oi, o_pi, o_po, o_j};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bus;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  st;
        logic [10:0] ctl;
        logic        en;
        logic [7:0]  ob;
        logic [3:0]  op;
        logic        zf;
        logic        of;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    // Expected opcode/flags as seen by the rows being appended.
    logic [3:0] eop;
    logic       fz;
    logic       fo;

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic row(input logic [7:0] bus, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] st, input logic [10:0] ctl, input logic en,
                       input logic [7:0] ob);
        vec_t v;
        v.bus = bus; v.a = a; v.b = b; v.st = st; v.ctl = ctl;
        v.en = en; v.ob = ob; v.op = eop; v.zf = fz; v.of = fo;
        vecs.push_back(v);
    endtask

    // T1..T3 of an instruction; the bus carries junk except at T3.
    task automatic fetch(input logic [7:0] ir, input logic [7:0] a, input logic [7:0] b);
        row(8'hA5, a, b, 3'd0, PO | MI, 1'b0, 8'h00);
        row(8'h5A, a, b, 3'd1, PI,      1'b0, 8'h00);
        row(ir,    a, b, 3'd2, RO,      1'b0, 8'h00);
        eop = ir[7:4];
    endtask

    initial begin
        rst_n = 1'b0;
        i_bus = 8'h1A;
        i_a   = 8'h00;
        i_b   = 8'h00;

        // Run an ADD up to T5, then abort it with reset.
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_state", -1, 16'(o_state), 16'd4);
        chk("pre_reset_ctl",   -1, 16'(act_ctl), 16'(RO | BI));
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state",  -1, 16'(o_state),  16'd0);
        chk("reset_ctl",    -1, 16'(act_ctl),  16'd0);
        chk("reset_bus_en", -1, 16'(o_bus_en), 16'd0);
        chk("reset_opcode", -1, 16'(o_opcode), 16'd0);
        @(posedge clk); #1;
        chk("reset_hold_state", -1, 16'(o_state), 16'd0);
        rst_n = 1'b1;

        // Build the program table.
        eop = 4'h0; fz = 1'b0; fo = 1'b0;
        // LDA 9
        fetch(8'h09, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, MI,      1'b1, 8'h09);
        row(8'h00, 8'h00, 8'h00, 3'd4, RO | AI, 1'b0, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd5, NONE,    1'b0, 8'h00);
        // ADD A: F0 + 20 wraps to 10 with carry
        fetch(8'h1A, 8'hF0, 8'h20);
        row(8'h00, 8'hF0, 8'h20, 3'd3, MI,      1'b1, 8'h0A);
        row(8'h00, 8'hF0, 8'h20, 3'd4, RO | BI, 1'b0, 8'h00);
        row(8'h00, 8'hF0, 8'h20, 3'd5, AI,      1'b1, 8'h10);
        fz = 1'b0; fo = 1'b1;
        // SUB B: 05 - 05 = 00, no borrow
        fetch(8'h2B, 8'h05, 8'h05);
        row(8'h00, 8'h05, 8'h05, 3'd3, MI,      1'b1, 8'h0B);
        row(8'h00, 8'h05, 8'h05, 3'd4, RO | BI, 1'b0, 8'h00);
        row(8'h00, 8'h05, 8'h05, 3'd5, AI,      1'b1, 8'h00);
        fz = 1'b1; fo = 1'b1;
        // JZ 3 taken
        fetch(8'h53, 8'h05, 8'h05);
        row(8'h00, 8'h05, 8'h05, 3'd3, J,       1'b1, 8'h03);
        // SUB C: 03 - 05 = FE, borrow clears overflow
        fetch(8'h2C, 8'h03, 8'h05);
        row(8'h00, 8'h03, 8'h05, 3'd3, MI,      1'b1, 8'h0C);
        row(8'h00, 8'h03, 8'h05, 3'd4, RO | BI, 1'b0, 8'h00);
        row(8'h00, 8'h03, 8'h05, 3'd5, AI,      1'b1, 8'hFE);
        fz = 1'b0; fo = 1'b0;
        // JC 7 not taken
        fetch(8'h67, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, NONE,    1'b0, 8'h00);
        // STA D
        fetch(8'h3D, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, MI,      1'b1, 8'h0D);
        row(8'h00, 8'h00, 8'h00, 3'd4, AO | RI, 1'b0, 8'h00);
        // JMP 5
        fetch(8'h45, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, J,       1'b1, 8'h05);
        // JZ 8 not taken
        fetch(8'h58, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, NONE,    1'b0, 8'h00);
        // undefined opcode 7 acts as NOP
        fetch(8'h70, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, NONE,    1'b0, 8'h00);
        // OUT
        fetch(8'hE0, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, AO | OI, 1'b0, 8'h00);
        // HLT
        fetch(8'hF0, 8'h00, 8'h00);
        row(8'h00, 8'h00, 8'h00, 3'd3, H,       1'b0, 8'h00);

        // Apply each row for one clock, scoreboarding the expectation.
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            i_bus = vecs[i].bus;
            i_a   = vecs[i].a;
            i_b   = vecs[i].b;
            sb.push_back(vecs[i]);
            #3;
            e = sb.pop_front();
            chk("state",  i, 16'(o_state),  16'(e.st));
            chk("ctl",    i, 16'(act_ctl),  16'(e.ctl));
            chk("bus_en", i, 16'(o_bus_en), 16'(e.en));
            if (e.en) begin
                chk("bus", i, 16'(o_bus), 16'(e.ob));
            end
            chk("opcode", i, 16'(o_opcode),        16'(e.op));
            chk("zero",   i, 16'(o_flag_zero),     16'(e.zf));
            chk("ovf",    i, 16'(o_flag_overflow), 16'(e.of));
            @(posedge clk); #1;
        end

        // Halted: frozen in T4 with only o_halt asserted.
        for (int k = 0; k < 10; k++) begin
            chk("halt_state", k, 16'(o_state), 16'd3);
            chk("halt_ctl",   k, 16'(act_ctl), 16'(H));
            i_bus = 8'h09;
            @(posedge clk); #1;
        end
        chk("halt_opcode", -1, 16'(o_opcode), 16'hF);

        // Reset releases the halt and restarts fetch.
        rst_n = 1'b0;
        #1;
        chk("unhalt_ctl",   -1, 16'(act_ctl), 16'd0);
        chk("unhalt_state", -1, 16'(o_state), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("restart_ctl",   -1, 16'(act_ctl), 16'(PO | MI));
        chk("restart_flags", -1, 16'({o_flag_zero, o_flag_overflow}), 16'd0);
        @(posedge clk); #1;
        chk("restart_t2", -1, 16'(o_state), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
